// File: rtl/round_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : round_scheduler
//  Purpose  : Multi-round game timer. Issues single-cycle tick enables at a
//             programmable period, counts ticks per round, idles for a fixed
//             gap between rounds and shortens the period each round.
//  Revision : 1.0 - initial release
// ============================================================================
module round_scheduler #(
    parameter int unsigned DIV_BASE        = 6250000,
    parameter int unsigned DIV_STEP        = 625000,
    parameter int unsigned DIV_MIN         = 1250000,
    parameter int unsigned ROUNDS          = 8,
    parameter int unsigned TICKS_PER_ROUND = 10,
    parameter int unsigned GAP_CYCLES      = 25000000
) (
    input  logic        iclk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        abort,
    output logic        tick,
    output logic        round_end,
    output logic        done,
    output logic        busy,
    output logic [7:0]  round_num,
    output logic [15:0] tick_count,
    output logic [31:0] cur_div,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_PAUSED = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [31:0] c_DIV_BASE  = 32'(DIV_BASE);
    localparam logic [31:0] c_DIV_STEP  = 32'(DIV_STEP);
    localparam logic [31:0] c_DIV_MIN   = 32'(DIV_MIN);
    localparam logic [7:0]  c_ROUNDS    = 8'(ROUNDS);
    localparam logic [15:0] c_TICKS     = 16'(TICKS_PER_ROUND);
    localparam logic [31:0] c_GAP_LAST  = 32'(GAP_CYCLES - 1);
    // Threshold at which subtracting one step still stays at or above the floor;
    // held in 33 bits so the sum itself cannot wrap.
    localparam logic [32:0] c_STEP_OK   = {1'b0, c_DIV_MIN} + {1'b0, c_DIV_STEP};

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_nxt;
    logic [31:0] r_gap;
    logic [31:0] w_gap_nxt;
    logic        w_tick_nxt;
    logic        w_round_end_nxt;
    logic        w_done_nxt;
    logic        w_busy_nxt;
    logic [7:0]  w_round_nxt;
    logic [15:0] w_tc_nxt;
    logic [15:0] w_tc_inc;
    logic [31:0] w_div_nxt;
    logic [31:0] w_div_shrunk;

    assign state        = r_state;
    assign w_tc_inc     = tick_count + 16'd1;
    assign w_div_shrunk = ({1'b0, cur_div} >= c_STEP_OK) ? (cur_div - c_DIV_STEP) : c_DIV_MIN;

    // Next-state and next-output decode; abort overrides pause, pause overrides counting
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_gap_nxt       = r_gap;
        w_tick_nxt      = 1'b0;
        w_round_end_nxt = 1'b0;
        w_round_nxt     = round_num;
        w_tc_nxt        = tick_count;
        w_div_nxt       = cur_div;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 32'd0;
            w_gap_nxt   = 32'd0;
            w_round_nxt = 8'd0;
            w_tc_nxt    = 16'd0;
            w_div_nxt   = c_DIV_BASE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_nxt = S_RUN;
                        w_cnt_nxt   = 32'd0;
                        w_gap_nxt   = 32'd0;
                        w_round_nxt = 8'd1;
                        w_tc_nxt    = 16'd0;
                        w_div_nxt   = c_DIV_BASE;
                    end
                end
                // A paused game whose pause has dropped counts on that same edge
                S_RUN, S_PAUSED: begin
                    if (pause) begin
                        w_state_nxt = S_PAUSED;
                    end else begin
                        w_state_nxt = S_RUN;
                        if (r_cnt == cur_div - 32'd1) begin
                            w_cnt_nxt  = 32'd0;
                            w_tick_nxt = 1'b1;
                            w_tc_nxt   = w_tc_inc;
                            if (w_tc_inc == c_TICKS) begin
                                w_round_end_nxt = 1'b1;
                                w_gap_nxt       = 32'd0;
                                w_state_nxt     = (round_num < c_ROUNDS) ? S_GAP : S_DONE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 32'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap == c_GAP_LAST) begin
                        w_state_nxt = S_RUN;
                        w_gap_nxt   = 32'd0;
                        w_cnt_nxt   = 32'd0;
                        w_tc_nxt    = 16'd0;
                        w_round_nxt = round_num + 8'd1;
                        w_div_nxt   = w_div_shrunk;
                    end else begin
                        w_gap_nxt = r_gap + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        w_done_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSED) || (w_state_nxt == S_GAP);
    end

    // State and registered outputs, cleared asynchronously
    always_ff @(posedge iclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 32'd0;
            r_gap      <= 32'd0;
            tick       <= 1'b0;
            round_end  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            round_num  <= 8'd0;
            tick_count <= 16'd0;
            cur_div    <= c_DIV_BASE;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gap      <= w_gap_nxt;
            tick       <= w_tick_nxt;
            round_end  <= w_round_end_nxt;
            done       <= w_done_nxt;
            busy       <= w_busy_nxt;
            round_num  <= w_round_nxt;
            tick_count <= w_tc_nxt;
            cur_div    <= w_div_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_round_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_round_scheduler
//  Purpose  : Directed self-checking bench for round_scheduler with small
//             parameters; a second instance exercises the period floor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_round_scheduler;

    logic        iclk;
    logic        reset;
    logic        start;
    logic        pause;
    logic        abort;

    logic        tick, round_end, done, busy;
    logic [7:0]  round_num;
    logic [15:0] tick_count;
    logic [31:0] cur_div;
    logic [2:0]  state;

    logic        f_tick, f_round_end, f_done, f_busy;
    logic [7:0]  f_round_num;
    logic [15:0] f_tick_count;
    logic [31:0] f_cur_div;
    logic [2:0]  f_state;

    int checks = 0;
    int errors = 0;

    round_scheduler #(
        .DIV_BASE(4), .DIV_STEP(1), .DIV_MIN(2),
        .ROUNDS(3), .TICKS_PER_ROUND(2), .GAP_CYCLES(3)
    ) u_dut (
        .iclk(iclk), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .tick(tick), .round_end(round_end), .done(done), .busy(busy),
        .round_num(round_num), .tick_count(tick_count), .cur_div(cur_div), .state(state)
    );

    round_scheduler #(
        .DIV_BASE(4), .DIV_STEP(5), .DIV_MIN(2),
        .ROUNDS(3), .TICKS_PER_ROUND(2), .GAP_CYCLES(3)
    ) u_floor (
        .iclk(iclk), .reset(reset), .start(start), .pause(pause), .abort(abort),
        .tick(f_tick), .round_end(f_round_end), .done(f_done), .busy(f_busy),
        .round_num(f_round_num), .tick_count(f_tick_count), .cur_div(f_cur_div), .state(f_state)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic adv(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
        #3;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round", 32'(round_num), 32'd0);
        chk("rst_tc", 32'(tick_count), 32'd0);
        chk("rst_div", cur_div, 32'd4);
        chk("rst_tick", 32'(tick), 32'd0);
        adv(2);
        reset = 1'b0;
        adv(1);

        // ---- full game; E0 is the edge that samples start ----
        start = 1'b1;
        adv(1);
        start = 1'b0;
        chk("g_busy_e0", 32'(busy), 32'd1);
        chk("g_state_e0", 32'(state), 32'd1);
        chk("g_round_e0", 32'(round_num), 32'd1);
        adv(3);                                   // E0+3
        chk("g_tick_p3", 32'(tick), 32'd0);
        adv(1);                                   // E0+4
        chk("g_tick_p4", 32'(tick), 32'd1);
        chk("g_tc_p4", 32'(tick_count), 32'd1);
        chk("g_rend_p4", 32'(round_end), 32'd0);
        adv(1);                                   // E0+5
        chk("g_tick_p5", 32'(tick), 32'd0);
        adv(3);                                   // E0+8
        chk("g_tick_p8", 32'(tick), 32'd1);
        chk("g_rend_p8", 32'(round_end), 32'd1);
        chk("g_tc_p8", 32'(tick_count), 32'd2);
        adv(1);                                   // E0+9
        chk("g_state_gap", 32'(state), 32'd3);
        chk("g_tick_gap", 32'(tick), 32'd0);
        chk("g_rend_gap", 32'(round_end), 32'd0);
        adv(4);                                   // E0+13
        chk("g_tick_p13", 32'(tick), 32'd0);
        chk("g_round_p13", 32'(round_num), 32'd2);
        chk("g_div_p13", cur_div, 32'd3);
        chk("f_div_r2", f_cur_div, 32'd2);
        adv(1);                                   // E0+14
        chk("g_tick_p14", 32'(tick), 32'd1);
        chk("g_tc_p14", 32'(tick_count), 32'd1);
        adv(3);                                   // E0+17
        chk("g_tick_p17", 32'(tick), 32'd1);
        chk("g_rend_p17", 32'(round_end), 32'd1);
        adv(3);                                   // E0+20
        chk("g_round_p20", 32'(round_num), 32'd3);
        chk("g_div_p20", cur_div, 32'd2);
        chk("f_div_r3", f_cur_div, 32'd2);
        chk("f_round_r3", 32'(f_round_num), 32'd3);
        adv(2);                                   // E0+22
        chk("g_tick_p22", 32'(tick), 32'd1);
        chk("f_done_p22", 32'(f_done), 32'd1);
        adv(1);                                   // E0+23
        chk("g_tick_p23", 32'(tick), 32'd0);
        adv(1);                                   // E0+24
        chk("g_tick_p24", 32'(tick), 32'd1);
        chk("g_rend_p24", 32'(round_end), 32'd1);
        chk("g_tc_p24", 32'(tick_count), 32'd2);
        chk("g_done_p24", 32'(done), 32'd1);
        chk("g_state_p24", 32'(state), 32'd4);
        chk("g_busy_p24", 32'(busy), 32'd0);
        chk("g_round_p24", 32'(round_num), 32'd3);
        adv(2);                                   // DONE holds, no stray tick
        chk("g_tick_done", 32'(tick), 32'd0);
        chk("g_done_hold", 32'(done), 32'd1);
        chk("g_tc_done", 32'(tick_count), 32'd2);

        // ---- start from DONE restarts; new E0 ----
        start = 1'b1;
        adv(1);
        start = 1'b0;
        chk("r_state", 32'(state), 32'd1);
        chk("r_round", 32'(round_num), 32'd1);
        chk("r_tc", 32'(tick_count), 32'd0);
        chk("r_div", cur_div, 32'd4);
        chk("r_done", 32'(done), 32'd0);
        adv(1);                                   // E0+1
        // pause sampled at E0+2..E0+6; start in RUN must be ignored
        pause = 1'b1;
        start = 1'b1;
        adv(1);                                   // E0+2
        start = 1'b0;
        chk("p_state", 32'(state), 32'd2);
        chk("p_round", 32'(round_num), 32'd1);
        chk("p_busy", 32'(busy), 32'd1);
        adv(4);                                   // E0+6
        chk("p_state_hold", 32'(state), 32'd2);
        chk("p_tc_hold", 32'(tick_count), 32'd0);
        chk("p_tick_hold", 32'(tick), 32'd0);
        pause = 1'b0;
        adv(2);                                   // E0+8
        chk("p_tick_p8", 32'(tick), 32'd0);
        adv(1);                                   // E0+9
        chk("p_tick_p9", 32'(tick), 32'd1);
        chk("p_tc_p9", 32'(tick_count), 32'd1);

        // ---- pause on the terminal-count edge (cnt==3 at E0+13) ----
        adv(3);                                   // E0+12
        chk("pt_tick_p12", 32'(tick), 32'd0);
        pause = 1'b1;
        adv(1);                                   // E0+13
        chk("pt_tick_p13", 32'(tick), 32'd0);
        chk("pt_state", 32'(state), 32'd2);
        chk("pt_tc", 32'(tick_count), 32'd1);
        adv(1);                                   // still paused
        chk("pt_tick_held", 32'(tick), 32'd0);
        pause = 1'b0;
        adv(1);                                   // resume edge fires the tick
        chk("pt_tick_resume", 32'(tick), 32'd1);
        chk("pt_rend", 32'(round_end), 32'd1);
        chk("pt_tc2", 32'(tick_count), 32'd2);
        chk("pt_state_gap", 32'(state), 32'd3);

        // ---- abort during GAP of round 1 ----
        adv(1);
        chk("a_in_gap", 32'(state), 32'd3);
        abort = 1'b1;
        adv(1);
        abort = 1'b0;
        chk("a_state", 32'(state), 32'd0);
        chk("a_round", 32'(round_num), 32'd0);
        chk("a_div", cur_div, 32'd4);
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_tc", 32'(tick_count), 32'd0);
        chk("a_f_state", 32'(f_state), 32'd0);
        adv(2);
        chk("a_idle_hold", 32'(state), 32'd0);
        start = 1'b1;
        adv(1);                                   // new E0
        start = 1'b0;
        chk("a_restart_state", 32'(state), 32'd1);
        chk("a_restart_round", 32'(round_num), 32'd1);

        // ---- asynchronous reset during round 2 ----
        adv(14);                                  // E0+14: round 2 first tick
        chk("x_round2", 32'(round_num), 32'd2);
        chk("x_div3", cur_div, 32'd3);
        #2;
        reset = 1'b1;
        #1;                                       // no clock edge in between
        chk("x_state", 32'(state), 32'd0);
        chk("x_round", 32'(round_num), 32'd0);
        chk("x_tc", 32'(tick_count), 32'd0);
        chk("x_div", cur_div, 32'd4);
        chk("x_tick", 32'(tick), 32'd0);
        chk("x_busy", 32'(busy), 32'd0);
        adv(1);
        reset = 1'b0;
        adv(2);
        chk("x_idle_after", 32'(state), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
